// File: rtl/vlc_pkg.sv
// Shared constants, state encoding and length-mask helper for the VLC bit packer.
package vlc_pkg;

  localparam int VLC_WORD_W     = 32;
  localparam int VLC_MAX_CW_LEN = 32;

  typedef enum logic {
    RUN       = 1'b0,
    FLUSH_PAD = 1'b1
  } vlc_state_e;

  function automatic logic [31:0] vlc_len_mask(input logic [5:0] len);
    if (len >= 6'd32) return '1;
    return (32'h1 << len) - 32'h1;
  endfunction

endpackage

// File: rtl/vlc_bit_packer_if.sv
// Codeword input and packed-word output bundle of the VLC bit packer.
interface vlc_bit_packer_if #(
  parameter int CNT_W = 16
) ();
  logic             input_valid;
  logic [31:0]      sum;
  logic [31:0]      codeword_length;
  logic             flush;
  logic             word_valid;
  logic [31:0]      word;
  logic             word_last;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             error;

  modport master (
    output input_valid, sum, codeword_length, flush,
    input  word_valid, word, word_last, word_count, busy, error
  );

  modport slave (
    input  input_valid, sum, codeword_length, flush,
    output word_valid, word, word_last, word_count, busy, error
  );
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codewords into an MSB-first stream of 32-bit words.
//   state     | meaning
//   RUN       | append codewords, emit each completed word
//   FLUSH_PAD | emit zero-padded residual word with word_last, then clear
module vlc_bit_packer
  import vlc_pkg::*;
#(
  parameter int WORD_W = VLC_WORD_W,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         reset,
  vlc_bit_packer_if.slave bus
);

  localparam logic [6:0] WORD_BITS = 7'(WORD_W);

  vlc_state_e       state;
  logic [63:0]      acc;
  logic [5:0]       fill;
  logic             word_valid;
  logic [31:0]      word;
  logic             word_last;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             error;

  logic             len_bad;
  logic             len_zero;
  logic [5:0]       len;
  logic             append;
  logic [6:0]       shift;
  logic [63:0]      acc_app;
  logic [6:0]       fill_app;
  logic             emit;
  logic [63:0]      acc_nxt;
  logic [5:0]       fill_nxt;
  logic [CNT_W-1:0] cnt_base;

  always_comb begin
    len_bad  = bus.codeword_length > 32'(VLC_MAX_CW_LEN);
    len_zero = bus.codeword_length == 32'd0;
    len      = bus.codeword_length[5:0];
    append   = bus.input_valid && !len_zero && !len_bad && (state == RUN);
    // fill <= 31 and len <= 32 keep the shift in 1..63 whenever append is set
    shift    = 7'd64 - {1'b0, fill} - {1'b0, len};
    acc_app  = acc;
    fill_app = {1'b0, fill};
    if (append) begin
      acc_app  = acc | ({32'b0, bus.sum & vlc_len_mask(len)} << shift);
      fill_app = {1'b0, fill} + {1'b0, len};
    end
    emit     = fill_app >= WORD_BITS;
    acc_nxt  = emit ? (acc_app << 32) : acc_app;
    fill_nxt = emit ? 6'(fill_app - WORD_BITS) : fill_app[5:0];
    // a word_last shown this cycle restarts the count at the next edge
    cnt_base = (word_valid && word_last) ? '0 : word_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      acc        <= '0;
      fill       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
      word_last  <= 1'b0;
      word_count <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.input_valid && len_bad) error <= 1'b1;
          acc        <= acc_nxt;
          fill       <= fill_nxt;
          word_valid <= emit;
          word_count <= cnt_base;
          if (emit) begin
            word       <= acc_app[63:32];
            word_last  <= bus.flush && (fill_nxt == 6'd0);
            word_count <= cnt_base + 1'b1;
          end
          if (bus.flush) begin
            if (fill_nxt != 6'd0) begin
              state <= FLUSH_PAD;
              busy  <= 1'b1;
            end else if (!emit) begin
              word_count <= '0;
            end
          end
        end
        FLUSH_PAD: begin
          if (bus.input_valid && !len_zero) error <= 1'b1;
          word_valid <= 1'b1;
          word       <= acc[63:32];
          word_last  <= 1'b1;
          word_count <= cnt_base + 1'b1;
          acc        <= '0;
          fill       <= '0;
          state      <= RUN;
          busy       <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.word_valid = word_valid;
  assign bus.word       = word;
  assign bus.word_last  = word_last;
  assign bus.word_count = word_count;
  assign bus.busy       = busy;
  assign bus.error      = error;

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer with hand-computed expected words and flags.
module tb_vlc_bit_packer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_failed = 0;

  vlc_bit_packer_if #(.CNT_W(16)) bus ();

  vlc_bit_packer #(.WORD_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] s, input logic [31:0] l, input logic f);
    bus.input_valid     = v;
    bus.sum             = s;
    bus.codeword_length = l;
    bus.flush           = f;
    @(posedge clk);
    #1;
    bus.input_valid     = 1'b0;
    bus.sum             = '0;
    bus.codeword_length = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input logic last, input int cnt);
    check({tag, " valid"}, 64'(bus.word_valid), 64'd1);
    check({tag, " word"},  64'(bus.word),       64'(w));
    check({tag, " last"},  64'(bus.word_last),  64'(last));
    check({tag, " count"}, 64'(bus.word_count), 64'(cnt));
  endtask

  initial begin
    bus.input_valid     = 1'b0;
    bus.sum             = '0;
    bus.codeword_length = '0;
    bus.flush           = 1'b0;
    #12;
    check("rst valid", 64'(bus.word_valid), 64'd0);
    check("rst word",  64'(bus.word),       64'd0);
    check("rst count", 64'(bus.word_count), 64'd0);
    check("rst busy",  64'(bus.busy),       64'd0);
    check("rst error", 64'(bus.error),      64'd0);
    @(negedge clk) reset = 1'b0;

    // four bytes make one word
    step(1'b1, 32'hA5, 32'd8, 1'b0);
    check("b1 valid", 64'(bus.word_valid), 64'd0);
    step(1'b1, 32'h3C, 32'd8, 1'b0);
    step(1'b1, 32'hFF, 32'd8, 1'b0);
    step(1'b1, 32'h01, 32'd8, 1'b0);
    check_word("bytes", 32'hA53CFF01, 1'b0, 1);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check("idle valid", 64'(bus.word_valid), 64'd0);
    check("idle hold",  64'(bus.word),       64'hA53CFF01);

    // full-width word then 4-bit residual flushed through FLUSH_PAD
    step(1'b1, 32'h12345678, 32'd32, 1'b0);
    check_word("full", 32'h12345678, 1'b0, 2);
    step(1'b1, 32'h9, 32'd4, 1'b0);
    check("res valid", 64'(bus.word_valid), 64'd0);
    step(1'b0, 32'h0, 32'd0, 1'b1);
    check("pad busy", 64'(bus.busy), 64'd1);
    check("pad wv",   64'(bus.word_valid), 64'd0);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check_word("pad", 32'h90000000, 1'b1, 3);
    check("pad busy off", 64'(bus.busy), 64'd0);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check("pad cnt clr", 64'(bus.word_count), 64'd0);
    check("pad wv off",  64'(bus.word_valid), 64'd0);

    // masking of bits above the length
    step(1'b1, 32'hFFFFFFFF, 32'd3, 1'b0);
    step(1'b0, 32'h0, 32'd0, 1'b1);
    check("mask busy", 64'(bus.busy), 64'd1);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check_word("mask", 32'hE0000000, 1'b1, 1);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check("mask cnt clr", 64'(bus.word_count), 64'd0);

    // flush on exact word boundary: no pad cycle
    step(1'b1, 32'hDEADBEEF, 32'd32, 1'b1);
    check_word("exact", 32'hDEADBEEF, 1'b1, 1);
    check("exact busy", 64'(bus.busy), 64'd0);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check("exact busy2", 64'(bus.busy), 64'd0);
    check("exact wv2",   64'(bus.word_valid), 64'd0);
    check("exact cnt",   64'(bus.word_count), 64'd0);

    // illegal length, zero length, codeword during FLUSH_PAD
    step(1'b1, 32'hFFFFFFFF, 32'd33, 1'b0);
    check("len33 error", 64'(bus.error), 64'd1);
    check("len33 wv",    64'(bus.word_valid), 64'd0);
    step(1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
    check("len0 wv", 64'(bus.word_valid), 64'd0);
    step(1'b1, 32'hABCD1234, 32'd32, 1'b0);
    check_word("after err", 32'hABCD1234, 1'b0, 1);
    step(1'b1, 32'h5, 32'd4, 1'b1);
    check("err pad busy", 64'(bus.busy), 64'd1);
    step(1'b1, 32'h7, 32'd4, 1'b0);
    check_word("err pad", 32'h50000000, 1'b1, 2);
    check("err sticky", 64'(bus.error), 64'd1);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    step(1'b1, 32'h11223344, 32'd32, 1'b0);
    check_word("drop", 32'h11223344, 1'b0, 1);

    // reset with 20 bits buffered
    step(1'b1, 32'hABCDE, 32'd20, 1'b0);
    reset = 1'b1;
    #2;
    check("mrst valid", 64'(bus.word_valid), 64'd0);
    check("mrst word",  64'(bus.word),       64'd0);
    check("mrst last",  64'(bus.word_last),  64'd0);
    check("mrst count", 64'(bus.word_count), 64'd0);
    check("mrst error", 64'(bus.error),      64'd0);
    @(negedge clk) reset = 1'b0;
    step(1'b1, 32'hCAFEBABE, 32'd32, 1'b0);
    check_word("post rst", 32'hCAFEBABE, 1'b0, 1);

    // unaligned straddle: 20 + 20 bits, 8-bit residual flushed
    step(1'b1, 32'hABCDE, 32'd20, 1'b0);
    step(1'b1, 32'h12345, 32'd20, 1'b0);
    check_word("straddle", 32'hABCDE123, 1'b0, 2);
    step(1'b0, 32'h0, 32'd0, 1'b1);
    check("strad busy", 64'(bus.busy), 64'd1);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check_word("strad pad", 32'h45000000, 1'b1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/vlc_bit_packer.md
# vlc_bit_packer

Packs the variable-length codewords produced by the entropy-coding stages (AC level, AC run, DC coefficients) into a contiguous MSB-first stream of 32-bit words. It sits directly downstream of the AC-level coefficient encoder and consumes its `output_valid` / `sum_n_n` / `codeword_length_n_n` triple unchanged. A flush request pads the final partial word with zeros and marks it last, closing the slice bitstream.

## Interface
- `WORD_W`, default 32: output word width. Only 32 is supported.
- `CNT_W`, default 16: width of the emitted-word counter.
- `clk`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-high reset.
- `input_valid`  in  1  codeword present this cycle. There is no ready signal; the block must accept every cycle.
- `sum`  in  32  codeword, right-aligned. Bits at or above `codeword_length` are ignored and masked off.
- `codeword_length`  in  32  codeword length in bits; legal range 0..32.
- `flush`  in  1  one-cycle pulse: end of stream after this cycle's codeword (if any).
- `word_valid`  out  1  `word` is valid this cycle.
- `word`  out  32  packed bits; the first-coded bit is in bit 31.
- `word_last`  out  1  final word of a flushed stream; asserted only together with `word_valid`.
- `word_count`  out  CNT_W  words emitted since reset or since the last completed flush. Wraps modulo 2^CNT_W.
- `busy`  out  1  high while in FLUSH_PAD.
- `error`  out  1  sticky; cleared only by reset.

## Operation
- State: a 64-bit accumulator `acc`, held left-aligned, plus a 6-bit fill count `fill` (0..63). Between cycles `fill` is always ≤31.
- Append rule: when `input_valid` is high and `len = codeword_length` is in 1..32, shift `sum & ((1<<len)-1)` in immediately after the current `fill` bits, then `fill += len`. A `len` of 0 is a no-op.
- Illegal length: if `codeword_length` > 32 while `input_valid` is high, set `error` and drop the codeword.
- Emit rule: if `fill` ≥ 32 after appending, emit the top 32 bits of `acc`, shift `acc` left by 32, and subtract 32 from `fill`. At most one word is emitted per cycle.
- FSM states: RUN and FLUSH_PAD. Reset state is RUN.
- RUN with `flush` high: apply append and emit as normal.
  - If the residual `fill` is 0, the word emitted this cycle (if any) carries `word_last`. If no word is emitted and `fill` was already 0, the stream is empty: emit nothing and just clear `word_count`.
  - If the residual `fill` is greater than 0, go to FLUSH_PAD.
- FLUSH_PAD: emit the top 32 bits of `acc`, zero-padded, with `word_last` set. Then clear `acc`, `fill` and `word_count`, and return to RUN.
  - `input_valid` with nonzero length in this state: drop the codeword and set `error`.
  - `flush` in this state is ignored.
- `word_count` increments on every emitted word. On a `word_last` word, the counter is cleared on the following cycle instead of incrementing.
- Reset values: `word_valid`=0, `word`=0, `word_last`=0, `word_count`=0, `busy`=0, `error`=0, `acc`=0, `fill`=0, state=RUN.
- Reset asserted mid-stream discards all buffered bits without emitting anything.

## Timing
- All outputs are registered. A word completed by the input at cycle N appears with `word_valid` high at cycle N+1.
- The padded flush word appears at N+2 when `flush` arrives at cycle N with residual bits.
- Sustained throughput is one codeword per cycle, so output averages at most one word per cycle. The ≤31-bit carry invariant guarantees no overflow.
- `busy` is high for exactly one cycle per padded flush.
- `word`, `word_last` and `word_count` are held at their previous value when `word_valid` is low. Only `word_valid` qualifies them.

## Structure
- Shared package `vlc_pkg` holds:
  - `VLC_WORD_W` = 32
  - `VLC_MAX_CW_LEN` = 32
  - the state enum RUN / FLUSH_PAD
- No sub-module: the mask-and-shift is inline combinational logic feeding the `acc` register.
- An optional helper `vlc_len_mask` (length to 32-bit mask) may live in `vlc_pkg` as a function.

## Test plan
- **Four 8-bit codewords**: inputs 0xA5, 0x3C, 0xFF, 0x01, each length 8, on consecutive cycles → one word 0xA53CFF01 in the cycle after the 4th input; `word_count`=1.
- **Full-width straddle**: 0x12345678 length 32, then 0x9 length 4, then `flush` → word 0x12345678, then padded word 0x90000000 with `word_last`. `busy` is high for 1 cycle and `word_count` returns to 0.
- **Masking**: `sum`=0xFFFFFFFF length 3, then `flush` → 0xE0000000 with `word_last`.
- **Flush on exact boundary**: 0xDEADBEEF length 32 together with `flush` → single word 0xDEADBEEF with `word_last`; no FLUSH_PAD cycle.
- **Errors**: length 33 with `input_valid` → no bits appended and `error`=1. A codeword arriving during FLUSH_PAD is dropped and `error` stays at 1. Length 0 with `input_valid` → no state change.
- **Reset mid-stream**: 20 bits buffered, then `reset` pulsed → all outputs 0; next 0xCAFEBABE length 32 → emits 0xCAFEBABE.
